// File: rtl/uart_rx_fifo_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_pkg
//   Shared definitions for the UART receive-side buffering logic: the data
//   width of a received character and the state encoding of the frame-capture
//   FSM that turns each rfin high period into a single push request.
// -----------------------------------------------------------------------------
package uart_rx_fifo_pkg;

    localparam int UART_DATA_W = 8;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

    // Capture FSM: wait for the synchronized frame-done level to rise, push
    // once, then wait for it to fall before arming again.
    typedef enum logic {
        WAIT_HIGH = 1'b0,
        WAIT_LOW  = 1'b1
    } cap_state_e;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_if
//   CPU-side bus bundle of the UART receive FIFO.
//   master : bus logic / CPU  (drives en, rd_en, clr_ovr)
//   slave  : uart_rx_fifo     (drives rd_data, rd_valid, count, full, overrun)
//   Signals:
//     en       receive enable from the control register
//     rd_en    pop request; ignored while rd_valid is low
//     clr_ovr  clears the sticky overrun flag
//     rd_data  head byte (show-ahead), 8'h00 when empty
//     rd_valid FIFO not empty
//     count    number of stored bytes, 0..DEPTH
//     full     count == DEPTH
//     overrun  sticky: a frame was dropped
// -----------------------------------------------------------------------------
interface uart_rx_fifo_if
    import uart_rx_fifo_pkg::*;
#(
    parameter int ADDR_W = 4
) ();

    logic         en;
    logic         rd_en;
    logic         clr_ovr;
    uart_byte_t   rd_data;
    logic         rd_valid;
    logic [ADDR_W:0] count;
    logic         full;
    logic         overrun;

    modport master (
        output en, rd_en, clr_ovr,
        input  rd_data, rd_valid, count, full, overrun
    );

    modport slave (
        input  en, rd_en, clr_ovr,
        output rd_data, rd_valid, count, full, overrun
    );

endinterface

// File: rtl/uart_rx_fifo_sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
//   STAGES-deep single-bit synchronizer with asynchronous active-high reset.
//   Ports:
//     clk  system clock
//     rst  asynchronous active-high reset, clears every stage to 0
//     d_i  asynchronous input level
//     q_o  synchronized level (last stage)
// -----------------------------------------------------------------------------
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // NOTE: clocked state is always assigned with <= so every flop samples the
    // pre-edge value of its neighbour; with = the chain would collapse to one flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//   Receive-side buffer for a bit-rate UART receiver. Each completed frame
//   (rfin_in high period) pushes the received byte once into a show-ahead
//   FIFO that the CPU-side bus logic drains through a pop handshake.
//   Ports:
//     clk       system clock
//     rst       asynchronous active-high reset
//     rfin_in   frame-done level from the receiver (asynchronous)
//     rdata_in  received byte, stable while rfin_in is high
//     read_ce   registered receiver enable = en & ~full
//     bus       CPU-side bundle (uart_rx_fifo_if.slave)
// -----------------------------------------------------------------------------
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rfin_in,
    input  uart_byte_t     rdata_in,
    output logic           read_ce,
    uart_rx_fifo_if.slave  bus
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // Frame-done synchronizer
    // ------------------------------------------------------------------
    logic rfin_s;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_rfin_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rfin_in),
        .q_o (rfin_s)
    );

    // ------------------------------------------------------------------
    // Capture FSM: one registered push request per rfin high period.
    // A level that stays high while en toggles is held in WAIT_LOW and is
    // therefore never pushed twice.
    // ------------------------------------------------------------------
    cap_state_e state_q;
    logic       push_req_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= WAIT_HIGH;
            push_req_q <= 1'b0;
        end else begin
            push_req_q <= 1'b0;
            case (state_q)
                WAIT_HIGH: begin
                    if (rfin_s && bus.en) begin
                        push_req_q <= 1'b1;
                        state_q    <= WAIT_LOW;
                    end
                end
                WAIT_LOW: begin
                    if (!rfin_s) begin
                        state_q <= WAIT_HIGH;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage, pointers and status
    // ------------------------------------------------------------------
    uart_byte_t        mem_q [DEPTH];
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              rd_valid_q;
    logic              full_q, full_d;
    logic              overrun_q, overrun_d;
    logic              read_ce_q;
    uart_byte_t        rd_data_q, rd_data_d;
    logic              pop_ok;
    logic              push_ok;
    logic              push_drop;

    // NOTE: every signal written here gets a default before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        pop_ok    = bus.rd_en && rd_valid_q;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push_ok   = push_req_q && (!full_q || pop_ok);
        push_drop = push_req_q && !push_ok;

        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;

        if (push_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop_ok) begin
            rptr_d = rptr_q + 1'b1;
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        full_d    = (count_d == DEPTH_CNT);
        // Set wins over clear.
        overrun_d = push_drop || (overrun_q && !bus.clr_ovr);

        // Next head byte. When the new head is the slot being written in this
        // same cycle (push into empty, or push+pop with one entry) the memory
        // does not hold it yet, so forward the incoming byte.
        if (count_d == '0) begin
            rd_data_d = '0;
        end else if (push_ok && (rptr_d == wptr_q)) begin
            rd_data_d = rdata_in;
        end else begin
            rd_data_d = mem_q[rptr_d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            full_q     <= 1'b0;
            overrun_q  <= 1'b0;
            read_ce_q  <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            rd_valid_q <= (count_d != '0);
            full_q     <= full_d;
            overrun_q  <= overrun_d;
            read_ce_q  <= bus.en & ~full_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // NOTE: the byte array carries no reset; validity is tracked by the
    // pointers and count, so stale contents are never observable.
    // rdata_in is sampled without synchronization: the receiver holds it
    // stable for as long as rfin is high, which spans the push cycle.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= rdata_in;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign read_ce      = read_ce_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.count    = count_q;
    assign bus.full     = full_q;
    assign bus.overrun  = overrun_q;

endmodule
